// File: rtl/uart_order_parser.sv
// rtl/uart_order_parser.sv - assembles 9-byte order frames from a UART byte stream
module uart_order_parser #(
    parameter int         TIMEOUT_CLKS = 104_167,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        ord_valid,
    input  logic        ord_ready,
    output logic [1:0]  ord_type,
    output logic [31:0] ord_price,
    output logic [15:0] ord_qty,
    output logic        err_csum,
    output logic        err_type,
    output logic        err_timeout,
    output logic        err_drop
);
    localparam int CW = $clog2(TIMEOUT_CLKS) + 1;

    typedef enum logic [1:0] {HUNT, TYPE, PAYLOAD, CHECK} state_t;

    state_t        state, state_nx;
    logic [2:0]    idx, idx_nx;
    logic [7:0]    csum, csum_nx;
    logic [1:0]    type_r, type_nx;
    logic [47:0]   shreg, shreg_nx;
    logic [CW-1:0] tcnt, tcnt_nx;
    logic          good, e_csum, e_type, e_to, load;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        csum_nx  = csum;
        type_nx  = type_r;
        shreg_nx = shreg;
        good     = 1'b0;
        e_csum   = 1'b0;
        e_type   = 1'b0;
        e_to     = 1'b0;
        tcnt_nx  = (state == HUNT || in_valid) ? '0 : tcnt + CW'(1);
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (state != HUNT && !in_valid && tcnt == CW'(TIMEOUT_CLKS - 1)) begin
            e_to     = 1'b1;
            state_nx = HUNT;
            tcnt_nx  = '0;
        end else if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_data == SYNC_BYTE) state_nx = TYPE;
                end
                TYPE: begin
                    if (in_data == 8'd1 || in_data == 8'd2 || in_data == 8'd3) begin
                        type_nx  = in_data[1:0];
                        csum_nx  = in_data;
                        idx_nx   = 3'd0;
                        state_nx = PAYLOAD;
                    end else begin
                        e_type   = 1'b1;
                        state_nx = HUNT;
                    end
                end
                PAYLOAD: begin
                    shreg_nx = {shreg[39:0], in_data};
                    csum_nx  = csum ^ in_data;
                    idx_nx   = idx + 3'd1;
                    if (idx == 3'd5) state_nx = CHECK;
                end
                CHECK: begin
                    if (in_data == csum) good = 1'b1;
                    else                 e_csum = 1'b1;
                    state_nx = HUNT;
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // A good frame may replace the held order only when that order leaves this cycle.
    assign load = good && (!ord_valid || ord_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= '0;
            csum        <= '0;
            type_r      <= '0;
            shreg       <= '0;
            tcnt        <= '0;
            ord_valid   <= 1'b0;
            ord_type    <= '0;
            ord_price   <= '0;
            ord_qty     <= '0;
            err_csum    <= 1'b0;
            err_type    <= 1'b0;
            err_timeout <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            csum        <= csum_nx;
            type_r      <= type_nx;
            shreg       <= shreg_nx;
            tcnt        <= tcnt_nx;
            err_csum    <= e_csum;
            err_type    <= e_type;
            err_timeout <= e_to;
            err_drop    <= good && !load;
            if (load) begin
                ord_valid <= 1'b1;
                ord_type  <= type_r;
                ord_price <= shreg[47:16];
                ord_qty   <= shreg[15:0];
            end else if (ord_valid && ord_ready) begin
                ord_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/uart_order_parser.md
Name: uart_order_parser

Overview:
- Consumes the byte stream from the UART receiver (rx_data/rx_ready) and assembles fixed-format 9-byte order frames.
- Checks sync, message type and checksum.
- Presents each decoded order to the matching engine on a valid/ready interface.
- Flags malformed, timed-out and dropped frames with single-cycle error pulses.

Parameters:
- TIMEOUT_CLKS, 104_167, maximum clk cycles allowed between consecutive bytes inside a frame (about 2 byte times at 9600 baud, 50 MHz).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  8  received byte, from UART rx_data
- in_valid  in  1  one-cycle strobe, byte available, from UART rx_ready; no backpressure
- ord_valid  out  1  decoded order available
- ord_ready  in  1  consumer accepts order
- ord_type  out  2  1=buy, 2=sell, 3=cancel
- ord_price  out  32  price, big-endian on wire
- ord_qty  out  16  quantity, big-endian on wire
- err_csum  out  1  pulse: checksum mismatch
- err_type  out  1  pulse: illegal type byte
- err_timeout  out  1  pulse: inter-byte timeout mid-frame
- err_drop  out  1  pulse: good frame dropped because output still occupied

Behaviour:
- Frame layout: SYNC, TYPE, P3, P2, P1, P0, Q1, Q0, CSUM. CSUM = XOR of TYPE through Q0 (7 bytes).
- Reset: state HUNT; ord_valid=0, ord_type=0, ord_price=0, ord_qty=0; all err_*=0; timeout counter=0; running XOR=0.
- State machine:
  - HUNT: in_valid and in_data==SYNC_BYTE -> TYPE. Any other byte is ignored silently; no error.
  - TYPE: on byte, if value is 1..3, latch type, XOR:=byte, -> PAYLOAD with index 0. Otherwise pulse err_type and -> HUNT. A second SYNC byte here is an illegal type (0xA5), so err_type fires.
  - PAYLOAD: shift 6 bytes into a price/qty shift register MSB-first and XOR each byte. After the 6th byte -> CHECK.
  - CHECK: on byte, if it equals the XOR, the frame is good. Otherwise pulse err_csum. -> HUNT in both cases.
- Good frame:
  - If ord_valid==0, or ord_valid==1 and ord_ready==1 in the same cycle: load ord_* and assert ord_valid on the next cycle. Latency is 1 clk from the CSUM strobe.
  - Otherwise keep the old order, discard the new frame, and pulse err_drop.
- Output handshake: ord_valid holds with stable fields until a cycle where ord_valid and ord_ready are both 1, then clears the next cycle unless reloaded in that same cycle. Fields retain their last value after clearing.
- Timeout counter:
  - Active in TYPE, PAYLOAD and CHECK; cleared on every in_valid and in HUNT.
  - When count reaches TIMEOUT_CLKS-1 with in_valid=0: pulse err_timeout, -> HUNT, discard the partial frame.
  - in_valid in the same cycle as expiry: the byte wins and no timeout fires.
  - Counter width is clog2(TIMEOUT_CLKS)+1.
- Error pulses are exactly 1 cycle, registered. At most one err_* fires per frame.
- rst asserted mid-frame or with ord_valid=1 returns everything to reset values on the next edge. A partial frame is lost; no error pulse.

Test Plan:
- Frame A5 01 00 00 27 10 00 64 (XOR=0x52) sent as 52 -> ord_valid 1 clk after the last strobe; type=1, price=0x00002710 (10000), qty=0x0064 (100).
- Same frame with CSUM 0x53 -> err_csum for 1 cycle, ord_valid stays 0, parser accepts the next valid frame.
- Bytes 00 FF A5 07 -> no error on 00/FF; err_type on 07; a following good frame decodes correctly.
- A5 02 00 00, then idle for TIMEOUT_CLKS cycles -> err_timeout exactly once. Repeat with a byte on the expiry cycle -> no timeout, frame continues.
- Two good frames back-to-back with ord_ready held 0 -> first order held stable, err_drop on the second CSUM. Repeat with ord_ready=1 on the second CSUM cycle -> second order loaded, no err_drop.
- Assert rst after 5 bytes of a frame -> all outputs 0, state HUNT; the remaining 4 bytes are ignored unless they contain A5.
